// File: rtl/video_timing_gen.sv
// Raster timing generator: counts pixels/lines while the PLL is locked and enabled,
// and registers sync, data-enable, coordinates and strobes one cycle behind the counters.
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 49,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pll_locked,
  input  logic          enable,
  input  logic [CW-1:0] line_irq_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_irq
);
  localparam logic [31:0] H_TOTAL = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_ACT_W = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_W = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic          lock_s1;
  logic          locked_s;
  logic [CW-1:0] hc_p0;
  logic [CW-1:0] vc_p0;
  logic [31:0]   hc_w;
  logic [31:0]   vc_w;
  logic          h_last;
  logic          v_last;
  logic          de_d;
  logic          hs_d;
  logic          vs_d;
  logic          irq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      lock_s1  <= pll_locked;
      locked_s <= lock_s1;
    end
  end

  // Stage p0: raster counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_p0 <= '0;
      vc_p0 <= '0;
    end else if (!locked_s) begin
      hc_p0 <= '0;
      vc_p0 <= '0;
    end else if (enable) begin
      if (h_last) begin
        hc_p0 <= '0;
        vc_p0 <= v_last ? '0 : vc_p0 + CW'(1);
      end else begin
        hc_p0 <= hc_p0 + CW'(1);
      end
    end
  end

  assign hc_w   = 32'(hc_p0);
  assign vc_w   = 32'(vc_p0);
  assign h_last = (hc_w == H_TOTAL - 32'd1);
  assign v_last = (vc_w == V_TOTAL - 32'd1);
  assign de_d   = (hc_w < H_ACT_W) && (vc_w < V_ACT_W);
  assign hs_d   = (hc_w >= HS_BEG) && (hc_w < HS_END);
  assign vs_d   = (vc_w >= VS_BEG) && (vc_w < VS_END);
  assign irq_d  = (hc_w == H_ACT_W) && (vc_p0 == line_irq_y);

  // Stage p1: registered decode; strobes are cleared while paused so none repeat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
    end else if (!locked_s) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
    end else if (enable) begin
      hsync       <= hs_d ? HS_POL : ~HS_POL;
      vsync       <= vs_d ? VS_POL : ~VS_POL;
      de          <= de_d;
      x           <= hc_p0;
      y           <= vc_p0;
      line_start  <= (hc_p0 == '0);
      frame_start <= (hc_p0 == '0) && (vc_p0 == '0);
      line_irq    <= irq_d;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
    end
  end
endmodule
